// File: rtl/alu_cmd_sequencer_if.sv
// Signal bundle between the keypad front end, alu_cmd_sequencer and the shared ALU.
// The sequencer uses the slave view; the front end and ALU together form the master.
interface alu_cmd_sequencer_if #(
  parameter int OP_W  = 4,
  parameter int DEPTH = 4
) ();
  logic                   cmd_valid;
  logic [OP_W-1:0]        cmd_op;
  logic [15:0]            cmd_src;
  logic [15:0]            cmd_dst;
  logic                   cmd_ready;
  logic                   alu_start;
  logic [OP_W-1:0]        alu_op;
  logic [15:0]            alu_a;
  logic [15:0]            alu_b;
  logic                   alu_done;
  logic [15:0]            alu_res;
  logic [15:0]            ans;
  logic                   ans_valid;
  logic                   err_ovf;
  logic                   err_tmo;
  logic                   busy;
  logic [$clog2(DEPTH):0] count;

  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, alu_done, alu_res,
    output cmd_ready, alu_start, alu_op, alu_a, alu_b,
           ans, ans_valid, err_ovf, err_tmo, busy, count
  );

  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, alu_done, alu_res,
    input  cmd_ready, alu_start, alu_op, alu_a, alu_b,
           ans, ans_valid, err_ovf, err_tmo, busy, count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Queues keypad commands and issues them one at a time to the shared ALU,
// substituting the answer token with the running answer so commands chain.
module alu_cmd_sequencer #(
  parameter int          OP_W      = 4,
  parameter int          DEPTH     = 4,
  parameter logic [15:0] ANS_TOKEN = 16'hFFFF,
  parameter int          TMO_CYC   = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  alu_cmd_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam int ENT_W = OP_W + 32;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RESOLVE = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [2:0]       r_state;
  logic [TMO_W-1:0] r_tmo;
  logic [OP_W-1:0]  r_wk_op;
  logic [15:0]      r_wk_src;
  logic [15:0]      r_wk_dst;
  logic [OP_W-1:0]  r_alu_op;
  logic [15:0]      r_alu_a;
  logic [15:0]      r_alu_b;
  logic [15:0]      r_ans;
  logic             r_err_ovf;
  logic             r_err_tmo;
  logic             w_push;
  logic             w_pop;
  logic             w_full;

  function automatic logic [15:0] resolve_opnd(input logic [15:0] opnd,
                                               input logic [15:0] last_ans);
    return (opnd == ANS_TOKEN) ? last_ans : opnd;
  endfunction

  assign w_full = (r_count == FULL_CNT);
  assign w_push = bus.cmd_valid && !w_full;
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0);

  // Command FIFO storage and the working register loaded on pop
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= {bus.cmd_op, bus.cmd_src, bus.cmd_dst};
    if (w_pop)  {r_wk_op, r_wk_src, r_wk_dst} <= r_mem[r_rptr];
  end

  // FIFO bookkeeping and the issue/answer state machine
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_state   <= S_IDLE;
      r_tmo     <= '0;
      r_alu_op  <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_ans     <= '0;
      r_err_ovf <= 1'b0;
      r_err_tmo <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // A full FIFO drops the strobe even when a pop frees a slot this cycle
      if (bus.cmd_valid && w_full) r_err_ovf <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_pop) r_state <= S_RESOLVE;
        end
        S_RESOLVE: begin
          r_alu_op <= r_wk_op;
          r_alu_a  <= resolve_opnd(r_wk_src, r_ans);
          r_alu_b  <= resolve_opnd(r_wk_dst, r_ans);
          r_state  <= S_ISSUE;
        end
        S_ISSUE: begin
          r_tmo   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.alu_done) begin
            r_ans   <= bus.alu_res;
            r_state <= S_WRITE;
          end else if (r_tmo == TMO_LAST) begin
            r_err_tmo <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_WRITE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = !w_full;
  assign bus.alu_start = (r_state == S_ISSUE);
  assign bus.alu_op    = r_alu_op;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.ans       = r_ans;
  assign bus.ans_valid = (r_state == S_WRITE);
  assign bus.err_ovf   = r_err_ovf;
  assign bus.err_tmo   = r_err_tmo;
  assign bus.busy      = (r_state != S_IDLE) || (r_count != '0);
  assign bus.count     = r_count;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: directed scenarios plus a randomized
// command stream, with a behavioural ALU and command/answer reference queues.
module tb_alu_cmd_sequencer;
  localparam int          OP_W    = 4;
  localparam int          DEPTH   = 4;
  localparam int          TMO_CYC = 255;
  localparam logic [15:0] TOK     = 16'hFFFF;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] src;
    logic [15:0] dst;
  } cmd_t;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  int   cyc   = 0;
  int   n_pass = 0;
  int   n_total = 0;

  cmd_t        cmd_q[$];
  logic [15:0] ans_q[$];
  logic [15:0] mdl_ans = 16'h0;
  bit          alu_pend = 0, alu_stall = 0, alu_drop = 0, stray_req = 0;
  logic [15:0] pend_res = 16'h0, stray_res = 16'h0;
  int          pend_delay = 0, alu_lat_max = 0;
  int          n_ansv = 0;
  logic [15:0] last_start_a = 16'h0;

  alu_cmd_sequencer_if #(.OP_W(OP_W), .DEPTH(DEPTH)) bus ();

  alu_cmd_sequencer #(
    .OP_W(OP_W), .DEPTH(DEPTH), .ANS_TOKEN(TOK), .TMO_CYC(TMO_CYC)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return {a[7:0], b[7:0]} ^ {12'h0, op};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compares every issue and every answer pulse against the model
  initial begin
    cmd_t        mc;
    logic [15:0] ea, eb, ex;
    forever begin
      @(negedge CLK);
      if (bus.alu_start === 1'b1) begin
        last_start_a = bus.alu_a;
        if (cmd_q.size() == 0) begin
          n_total++;
          $display("FAIL start_unexpected: alu_start op=%0h a=%0h b=%0h with nothing queued",
                   bus.alu_op, bus.alu_a, bus.alu_b);
        end else begin
          mc = cmd_q.pop_front();
          ea = (mc.src == TOK) ? mdl_ans : mc.src;
          eb = (mc.dst == TOK) ? mdl_ans : mc.dst;
          chk("issue_op", bus.alu_op, mc.op);
          chk("issue_a", bus.alu_a, ea);
          chk("issue_b", bus.alu_b, eb);
          if (alu_drop) alu_drop = 0;
          else begin
            alu_pend   = 1;
            pend_res   = alu_fn(mc.op, ea, eb);
            pend_delay = $urandom_range(0, alu_lat_max);
          end
        end
      end
      if (bus.ans_valid === 1'b1) begin
        n_ansv++;
        if (ans_q.size() == 0) begin
          n_total++;
          $display("FAIL ansv_unexpected: ans_valid with ans=%0h, none expected", bus.ans);
        end else begin
          ex = ans_q.pop_front();
          chk("ans_value", bus.ans, ex);
        end
      end
    end
  end

  // Behavioural ALU: answers a captured issue after a random delay unless stalled
  initial begin
    bus.alu_done = 1'b0;
    bus.alu_res  = 16'h0;
    forever begin
      @(posedge CLK); #2;
      bus.alu_done = 1'b0;
      if (stray_req) begin
        bus.alu_done = 1'b1;
        bus.alu_res  = stray_res;
        stray_req    = 0;
      end else if (alu_pend && !alu_stall) begin
        if (pend_delay == 0) begin
          bus.alu_done = 1'b1;
          bus.alu_res  = pend_res;
          mdl_ans      = pend_res;
          ans_q.push_back(pend_res);
          alu_pend     = 0;
        end else begin
          pend_delay--;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic at_neg(input int n);
    while (cyc < n) tick();
    @(negedge CLK);
  endtask

  task automatic send(input logic [3:0] op, input logic [15:0] src, input logic [15:0] dst,
                      input bit acc, output int c);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_src   = src;
    bus.cmd_dst   = dst;
    c = cyc;
    if (acc) cmd_q.push_back(cmd_t'({op, src, dst}));
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((cmd_q.size() != 0 || alu_pend || bus.busy !== 1'b0) && n < 3000) begin
      tick();
      n++;
    end
    n_total++;
    if (n < 3000) n_pass++;
    else $display("FAIL %s_drain: busy=%0b queued=%0d after %0d cycles", name, bus.busy, cmd_q.size(), n);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_ctl"}, {bus.alu_start, bus.ans_valid, bus.err_ovf, bus.err_tmo, bus.busy, bus.cmd_ready},
        6'b000001);
    chk({name, "_cnt"}, bus.count, 0);
    chk({name, "_op"}, bus.alu_op, 0);
    chk({name, "_ab"}, {bus.alu_a, bus.alu_b}, 0);
    chk({name, "_ans"}, bus.ans, 0);
  endtask

  initial begin
    int          c, c2, s, nv0;
    logic [15:0] a0, rs, rd;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_src   = '0;
    bus.cmd_dst   = '0;
    RESET = 1'b1;
    repeat (3) tick();
    @(negedge CLK);
    chk_reset("rst");
    tick();
    RESET = 1'b0;
    tick();

    // Single command latency
    alu_lat_max = 0;
    send(4'd0, 16'd3, 16'd4, 1, c);
    at_neg(c + 3);
    chk("t1_start", bus.alu_start, 1);
    chk("t1_ab", {bus.alu_a, bus.alu_b}, {16'd3, 16'd4});
    tick(); at_neg(c + 4);
    chk("t1_start_pulse", bus.alu_start, 0);
    tick(); at_neg(c + 5);
    chk("t1_ansv", {bus.ans_valid, bus.ans}, {1'b1, 16'd7});
    tick(); at_neg(c + 6);
    chk("t1_idle", {bus.busy, bus.ans_valid}, 2'b00);
    tick();

    // Chaining through the answer token
    alu_lat_max = 3;
    nv0 = n_ansv;
    send(4'd0, 16'd5, 16'd6, 1, c);
    send(4'd1, TOK, 16'd1, 1, c2);
    drain("t2");
    chk("t2_chain_a", last_start_a, 16'd11);
    chk("t2_ans", bus.ans, 16'd10);
    chk("t2_pulses", n_ansv - nv0, 2);

    // Overflow with the ALU stalled: one popped, four held, the sixth dropped
    alu_stall = 1;
    alu_lat_max = 0;
    nv0 = n_ansv;
    for (int i = 0; i < 6; i++) send(4'(i), 16'(100 + i), 16'(7 * i + 1), (i < 5), c);
    at_neg(cyc);
    chk("t3_count", bus.count, DEPTH);
    chk("t3_ready", bus.cmd_ready, 0);
    chk("t3_ovf", bus.err_ovf, 1);
    tick();
    alu_stall = 0;
    drain("t3");
    chk("t3_ovf_sticky", bus.err_ovf, 1);
    chk("t3_pulses", n_ansv - nv0, 5);

    // Timeout, then a chained command still issues with the unchanged answer
    a0 = mdl_ans;
    alu_drop = 1;
    send(4'd0, 16'd100, 16'd200, 1, c);
    send(4'd0, TOK, 16'd1, 1, c2);
    s = c + 3;
    at_neg(s + TMO_CYC);
    chk("t4_tmo_before", bus.err_tmo, 0);
    tick(); at_neg(s + TMO_CYC + 1);
    chk("t4_tmo_set", bus.err_tmo, 1);
    chk("t4_ans_kept", bus.ans, a0);
    tick();
    drain("t4");
    chk("t4_ans_final", bus.ans, 16'(a0 + 16'd1));

    // Reset while waiting on the ALU, then a late alu_done
    alu_stall = 1;
    nv0 = n_ansv;
    send(4'd2, 16'd9, 16'd9, 1, c);
    at_neg(c + 5);
    chk("t5_busy_pre", bus.busy, 1);
    tick();
    RESET = 1'b1;
    tick();
    alu_pend = 0;
    cmd_q.delete();
    ans_q.delete();
    mdl_ans = 16'h0;
    RESET = 1'b0;
    stray_res = 16'hBEEF;
    stray_req = 1;
    @(negedge CLK);
    chk_reset("t5_rst");
    tick();
    alu_stall = 0;
    repeat (2) tick();
    @(negedge CLK);
    chk("t5_after", {bus.ans, bus.count, bus.busy}, 0);
    chk("t5_no_ansv", n_ansv - nv0, 0);
    tick();

    // Stray alu_done while idle
    send(4'd0, 16'h0010, 16'h0020, 1, c);
    drain("t6");
    nv0 = n_ansv;
    stray_res = 16'h1234;
    stray_req = 1;
    repeat (3) tick();
    @(negedge CLK);
    chk("t6_ans", bus.ans, 16'h0030);
    chk("t6_no_ansv", n_ansv - nv0, 0);
    chk("t6_busy", bus.busy, 0);
    tick();

    // Randomized stream kept within FIFO capacity
    alu_lat_max = 5;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && cmd_q.size() < DEPTH) begin
        rs = ($urandom_range(0, 3) == 0) ? TOK : 16'($urandom);
        rd = ($urandom_range(0, 3) == 0) ? TOK : 16'($urandom);
        send(4'($urandom_range(0, 15)), rs, rd, 1, c);
      end else begin
        tick();
      end
    end
    drain("t7");
    chk("t7_errs", {bus.err_ovf, bus.err_tmo}, 2'b00);
    chk("t7_ans", bus.ans, mdl_ans);
    chk("t7_ans_q", ans_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end
endmodule
